// File: rtl/load_store_unit.sv
// Load/store unit: handshaked FSM between the core datapath and data memory.
// Loads are lane-selected and sign/zero-extended; sub-word stores use a
// read-modify-write; misaligned or illegal-size requests fault without a
// memory access.
module load_store_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [WIDTH-1:0]  rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ready
);

    localparam int         LSB       = $clog2(WIDTH / 8);
    localparam int         SH_W      = LSB + 3;
    localparam logic [1:0] FULL_SIZE = 2'(LSB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE,
        S_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic               is_store_q, is_store_d;
    logic [1:0]         size_q, size_d;
    logic               is_signed_q, is_signed_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [WIDTH-1:0]   rd_word_q, rd_word_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;

    logic               req_fault;
    logic [SH_W-1:0]    shamt;
    logic [WIDTH-1:0]   mask;
    logic [WIDTH-1:0]   lane;
    logic               sign_bit;
    logic [WIDTH-1:0]   load_ext;
    logic [WIDTH-1:0]   merged;

    // Classify an incoming request: misaligned for its size, or dword on a 32-bit unit
    always_comb begin
        req_fault = 1'b0;
        case (size)
            2'd0:    req_fault = 1'b0;
            2'd1:    req_fault = addr[0];
            2'd2:    req_fault = |addr[1:0];
            default: req_fault = (WIDTH == 32) ? 1'b1 : |addr[2:0];
        endcase
    end

    // Lane selection, load extension and store merge from the latched request
    always_comb begin
        shamt = {addr_q[LSB-1:0], 3'b000};
        mask  = '1;
        case (size_q)
            2'd0:    mask = WIDTH'(8'hFF);
            2'd1:    mask = WIDTH'(16'hFFFF);
            2'd2:    mask = WIDTH'(32'hFFFF_FFFF);
            default: mask = '1;
        endcase
        lane     = mem_rdata >> shamt;
        sign_bit = lane[WIDTH-1];
        case (size_q)
            2'd0:    sign_bit = lane[7];
            2'd1:    sign_bit = lane[15];
            2'd2:    sign_bit = lane[31];
            default: sign_bit = lane[WIDTH-1];
        endcase
        load_ext = (is_signed_q && sign_bit) ? (lane | ~mask) : (lane & mask);
        merged   = (rd_word_q & ~(mask << shamt)) | ((wdata_q & mask) << shamt);
    end

    // Next-state and datapath-register update
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        size_d      = size_q;
        is_signed_d = is_signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_word_d   = rd_word_q;
        rdata_d     = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_store_d  = is_store;
                    size_d      = size;
                    is_signed_d = is_signed;
                    addr_d      = addr;
                    wdata_d     = wdata;
                    if (req_fault) begin
                        state_d = S_FAULT;
                    end else if (is_store && (size == FULL_SIZE)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (mem_ready) begin
                    rd_word_d = mem_rdata;
                    if (is_store_q) begin
                        state_d = S_WR;
                    end else begin
                        rdata_d = load_ext;
                        state_d = S_DONE;
                    end
                end
            end
            S_WR: begin
                if (mem_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and memory-side outputs decoded from the registered state
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE) || (state_q == S_FAULT);
        fault     = (state_q == S_FAULT);
        mem_req   = (state_q == S_RD) || (state_q == S_WR);
        mem_we    = (state_q == S_WR);
        mem_addr  = addr_q;
        mem_addr[LSB-1:0] = '0;
        mem_wdata = (size_q == FULL_SIZE) ? wdata_q : merged;
        rdata     = rdata_q;
    end

    // State and request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            is_store_q  <= 1'b0;
            size_q      <= '0;
            is_signed_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_word_q   <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            size_q      <= size_d;
            is_signed_q <= is_signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_word_q   <= rd_word_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit: byte-addressed reference memory,
// randomized and directed requests on a 32-bit instance, directed checks on
// a 64-bit instance.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance signals
    logic        reset, start, is_store, is_signed;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, done, fault, mem_req, mem_we, mem_ready;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    // 64-bit instance signals
    logic        rst64, start64, is_store64, is_signed64;
    logic [1:0]  size64;
    logic [31:0] addr64;
    logic [63:0] wdata64;
    logic        busy64, done64, fault64, mem_req64, mem_we64, mem_ready64;
    logic [63:0] rdata64, mem_wdata64, mem_rdata64;
    logic [31:0] mem_addr64;

    load_store_unit #(.WIDTH(32), .ADDR_W(32)) u_dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store), .size(size),
        .is_signed(is_signed), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .fault(fault), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    load_store_unit #(.WIDTH(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .reset(rst64), .start(start64), .is_store(is_store64), .size(size64),
        .is_signed(is_signed64), .addr(addr64), .wdata(wdata64), .busy(busy64),
        .done(done64), .fault(fault64), .rdata(rdata64), .mem_req(mem_req64),
        .mem_we(mem_we64), .mem_addr(mem_addr64), .mem_wdata(mem_wdata64),
        .mem_rdata(mem_rdata64), .mem_ready(mem_ready64)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory: DUT-facing word array and reference byte array over 0x100..0x13F
    logic [31:0] mem [16];
    logic [7:0]  rb  [64];
    logic [31:0] exp_rdata = '0;

    task automatic set_word(input int w, input logic [31:0] v);
        mem[w] = v;
        for (int i = 0; i < 4; i++) rb[4*w+i] = 8'(v >> (8*i));
    endtask

    function automatic logic [31:0] ref_load(input int a, input int nb, input bit sgn);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (64'(rb[a+i]) << (8*i));
        if (sgn && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
        return v[31:0];
    endfunction

    typedef struct {
        bit          is_fault;
        bit          st;
        logic [31:0] rdata;
        logic [31:0] word;
        logic [31:0] waddr;
        int          start_cyc;
    } exp_t;
    exp_t sbq[$];

    // Memory responder
    int rmode = 0;
    int stall_left = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: mem_ready = 1'b1;
            1: mem_ready = ($urandom_range(0, 3) != 0);
            default: begin
                mem_ready = (stall_left == 0);
                if (mem_req && stall_left > 0) stall_left--;
            end
        endcase
        mem_rdata = mem_req ? mem[mem_addr[5:2]] : $urandom;
    end

    // Monitor: memory writes, request stability, completion scoreboard
    bit          req_seen = 1'b0;
    bit          hold_v = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    logic [31:0] last_waddr = '0, last_wdata = '0;
    int          last_lat = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (mem_req) begin
                req_seen = 1'b1;
                if (hold_v) begin
                    chk("hold_addr", 64'(mem_addr), 64'(h_addr));
                    chk("hold_we", 64'(mem_we), 64'(h_we));
                    chk("hold_wdata", 64'(mem_wdata), 64'(h_wdata));
                end
                hold_v  = !mem_ready;
                h_addr  = mem_addr;
                h_we    = mem_we;
                h_wdata = mem_wdata;
                if (mem_ready && mem_we) begin
                    mem[mem_addr[5:2]] = mem_wdata;
                    last_waddr = mem_addr;
                    last_wdata = mem_wdata;
                end
            end else begin
                hold_v = 1'b0;
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("spurious_done", 64'(done), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("fault", 64'(fault), 64'(e.is_fault));
                    chk("rdata", 64'(rdata), 64'(e.rdata));
                    chk("busy_at_done", 64'(busy), 64'd1);
                    if (e.is_fault) chk("fault_no_req", 64'(req_seen), 64'd0);
                    if (e.st && !e.is_fault) chk("mem_word", 64'(mem[e.waddr[5:2]]), 64'(e.word));
                    last_lat = cyc - e.start_cyc;
                end
            end
        end
    end

    task automatic issue(input bit st, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int nb, t, b;
        t = 0;
        while (busy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (busy) chk("idle_wait", 64'(busy), 64'd0);
        nb = 1 << sz;
        e.is_fault = (sz == 2'd3) || ((int'(a[2:0]) % nb) != 0);
        e.st = st;
        e.waddr = {a[31:2], 2'b00};
        if (!e.is_fault) begin
            if (st) begin
                for (int i = 0; i < nb; i++) rb[int'(a[5:0]) + i] = 8'(wd >> (8*i));
            end else begin
                exp_rdata = ref_load(int'(a[5:0]), nb, sg);
            end
        end
        b = int'({a[5:2], 2'b00});
        e.rdata = exp_rdata;
        e.word = {rb[b+3], rb[b+2], rb[b+1], rb[b]};
        e.start_cyc = cyc;
        start = 1'b1; is_store = st; size = sz; is_signed = sg; addr = a; wdata = wd;
        req_seen = 1'b0;
        sbq.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        is_store = 1'($urandom); size = 2'($urandom); is_signed = 1'($urandom);
        addr = $urandom; wdata = $urandom;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sbq.size() != 0 || busy) && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        bit st, sg;
        logic [1:0] sz;
        logic [31:0] a;
        // 64-bit instance parked in reset until its own section
        rst64 = 1'b1; start64 = 1'b0; is_store64 = 1'b0; size64 = '0; is_signed64 = 1'b0;
        addr64 = '0; wdata64 = '0; mem_ready64 = 1'b1; mem_rdata64 = '0;

        for (int w = 0; w < 16; w++) set_word(w, $urandom);
        reset = 1'b1; start = 1'b1; is_store = 1'b0; size = 2'd2; is_signed = 1'b0;
        addr = 32'h104; wdata = '0; mem_ready = 1'b1; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_maddr", 64'(mem_addr), 64'd0);
        chk("rst_mwdata", 64'(mem_wdata), 64'd0);
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Signed / unsigned byte load
        rmode = 0;
        set_word(0, 32'h80123456);
        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
        chk("lb_maddr", 64'(mem_addr), 64'h100);
        wait_idle();
        chk("lb_s_val", 64'(rdata), 64'hFFFFFF80);
        chk("lb_lat", 64'(last_lat), 64'd2);
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        wait_idle();
        chk("lb_u_val", 64'(rdata), 64'h00000080);

        // Halfword store by read-modify-write
        set_word(0, 32'h11223344);
        issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD);
        wait_idle();
        chk("sh_wdata", 64'(last_wdata), 64'hABCD3344);
        chk("sh_waddr", 64'(last_waddr), 64'h100);
        chk("sh_lat", 64'(last_lat), 64'd3);

        // Full-word store latency
        issue(1'b1, 2'd2, 1'b0, 32'h108, 32'hCAFEF00D);
        wait_idle();
        chk("sw_lat", 64'(last_lat), 64'd2);

        // Misaligned word load faults
        issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
        wait_idle();
        chk("lw_fault_lat", 64'(last_lat), 64'd1);
        chk("lw_fault_rdata", 64'(rdata), 64'h00000080);

        // Stalled load plus ignored start while busy
        rmode = 2;
        stall_left = 5;
        issue(1'b0, 2'd2, 1'b1, 32'h104, 32'h0);
        @(posedge clk); #1;
        start = 1'b1; is_store = 1'b1; size = 2'd0; addr = 32'h108; wdata = 32'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        chk("stall_lat", 64'(last_lat), 64'd7);
        repeat (3) @(posedge clk);
        #1;
        chk("no_extra_txn", 64'(busy), 64'd0);

        // Randomized traffic
        rmode = 1;
        for (int n = 0; n < 300; n++) begin
            st = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom);
            a = 32'h100 + 32'($urandom_range(0, 63));
            if (sz != 2'd3 && $urandom_range(0, 9) < 7) a = a & ~((32'd1 << sz) - 32'd1);
            issue(st, sz, sg, a, $urandom);
        end
        rmode = 0;
        wait_idle();

        // 64-bit instance
        @(posedge clk); #1;
        rst64 = 1'b0;
        mem_ready64 = 1'b1;
        mem_rdata64 = 64'h8000000100000000;
        start64 = 1'b1; is_store64 = 1'b0; size64 = 2'd2; is_signed64 = 1'b1; addr64 = 32'h4;
        @(posedge clk); #1;
        start64 = 1'b0;
        chk("ld64_maddr", 64'(mem_addr64), 64'h0);
        @(posedge clk); #1;
        chk("ld64_done", 64'(done64), 64'd1);
        chk("ld64_rdata", rdata64, 64'hFFFFFFFF80000001);

        @(posedge clk); #1;
        mem_rdata64 = 64'h0123456789ABCDEF;
        start64 = 1'b1; is_store64 = 1'b0; size64 = 2'd3; is_signed64 = 1'b1; addr64 = 32'h8;
        @(posedge clk); #1;
        start64 = 1'b0;
        chk("ldd64_maddr", 64'(mem_addr64), 64'h8);
        @(posedge clk); #1;
        chk("ldd64_rdata", rdata64, 64'h0123456789ABCDEF);
        chk("ldd64_fault", 64'(fault64), 64'd0);

        @(posedge clk); #1;
        mem_rdata64 = 64'h1122334455667788;
        start64 = 1'b1; is_store64 = 1'b1; size64 = 2'd0; is_signed64 = 1'b0;
        addr64 = 32'h5; wdata64 = 64'h00000000000000AA;
        @(posedge clk); #1;
        start64 = 1'b0;
        @(posedge clk); #1;
        chk("sb64_we", 64'(mem_we64), 64'd1);
        chk("sb64_wdata", mem_wdata64, 64'h1122AA4455667788);
        repeat (2) @(posedge clk);
        #1;

        // Reset while a dword store is waiting in WR
        mem_ready64 = 1'b0;
        start64 = 1'b1; is_store64 = 1'b1; size64 = 2'd3; addr64 = 32'h10;
        wdata64 = 64'hDEADBEEF01234567;
        @(posedge clk); #1;
        start64 = 1'b0;
        chk("rst64_in_wr", 64'(mem_we64), 64'd1);
        rst64 = 1'b1;
        @(posedge clk); #1;
        rst64 = 1'b0;
        mem_ready64 = 1'b1;
        chk("rst64_req", 64'(mem_req64), 64'd0);
        chk("rst64_busy", 64'(busy64), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("rst64_no_done", 64'(done64), 64'd0);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
